// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared encodings and default sizes for the RAM arbiter
package ram_arbiter_pkg;
  localparam int M_DEF       = 8;
  localparam int N_DEF       = 8;
  localparam int LOCK_TO_DEF = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  typedef enum logic {
    PICK_RR    = 1'b0,
    PICK_FIXED = 1'b1
  } pick_mode_e;
endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-side signal bundle for the RAM arbiter
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int N = N_DEF
) ();
  logic         req0, req1;
  logic         we0, we1;
  logic         lock0, lock1;
  logic [N-1:0] addr0, addr1;
  logic [M-1:0] wdata0, wdata1;
  logic         gnt0, gnt1;
  logic         rvalid0, rvalid1;
  logic [M-1:0] rdata;
  logic         ram_cs, ram_rd, ram_wr;
  logic [N-1:0] ram_addr;
  logic [M-1:0] ram_din;
  logic [M-1:0] ram_dout;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_cs, ram_rd, ram_wr, ram_addr, ram_din
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_cs, ram_rd, ram_wr, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational two-way picker (round-robin or fixed priority)
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_rr_last,
  input  pick_mode_e i_mode,
  output logic [1:0] o_gnt
);
  logic w_take0;

  // On a conflict requester 0 wins when fixed priority is on or when 1 was served last
  assign w_take0  = i_req0 & (~i_req1 | (i_mode == PICK_FIXED) | i_rr_last);
  assign o_gnt[0] = w_take0;
  assign o_gnt[1] = i_req1 & ~w_take0;
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter/sequencer for the single-port data RAM
// RAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins) instead of round-robin.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int M       = M_DEF,
  parameter int N       = N_DEF,
  parameter int LOCK_TO = LOCK_TO_DEF
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);
`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam pick_mode_e MODE = PICK_FIXED;
`else
  localparam pick_mode_e MODE = PICK_RR;
`endif
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_TO - 1);

  logic [1:0]   r_state;
  logic         r_rr_last;
  logic [3:0]   r_lock_cnt;
  logic         r_p1_v, r_p1_id, r_p2_v, r_p2_id;
  logic         r_cs, r_rd, r_wr;
  logic [N-1:0] r_addr;
  logic [M-1:0] r_din;

  logic         w_r0, w_r1, w_acc, w_id, w_we, w_lock, w_own_req;
  logic [1:0]   w_gnt;
  logic [N-1:0] w_addr;
  logic [M-1:0] w_wdata;

  // A locked owner masks the other requester before it reaches the picker
  assign w_r0 = bus.req0 & (r_state != ST_OWN1);
  assign w_r1 = bus.req1 & (r_state != ST_OWN0);

  ram_arb_pick u_pick (
    .i_req0    (w_r0),
    .i_req1    (w_r1),
    .i_rr_last (r_rr_last),
    .i_mode    (MODE),
    .o_gnt     (w_gnt)
  );

  assign w_acc     = |w_gnt;
  assign w_id      = w_gnt[1];
  assign w_we      = w_id ? bus.we1    : bus.we0;
  assign w_lock    = w_id ? bus.lock1  : bus.lock0;
  assign w_addr    = w_id ? bus.addr1  : bus.addr0;
  assign w_wdata   = w_id ? bus.wdata1 : bus.wdata0;
  assign w_own_req = (r_state == ST_OWN1) ? bus.req1 : bus.req0;

  assign bus.gnt0     = w_gnt[0];
  assign bus.gnt1     = w_gnt[1];
  assign bus.rvalid0  = r_p2_v & ~r_p2_id;
  assign bus.rvalid1  = r_p2_v & r_p2_id;
  assign bus.rdata    = bus.ram_dout;
  assign bus.ram_cs   = r_cs;
  assign bus.ram_rd   = r_rd;
  assign bus.ram_wr   = r_wr;
  assign bus.ram_addr = r_addr;
  assign bus.ram_din  = r_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_last  <= 1'b1;
      r_lock_cnt <= 4'd0;
      r_p1_v     <= 1'b0;
      r_p1_id    <= 1'b0;
      r_p2_v     <= 1'b0;
      r_p2_id    <= 1'b0;
      r_cs       <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      r_cs    <= w_acc;
      r_rd    <= w_acc & ~w_we;
      r_wr    <= w_acc & w_we;
      r_p1_v  <= w_acc & ~w_we;
      r_p1_id <= w_id;
      r_p2_v  <= r_p1_v;
      r_p2_id <= r_p1_id;
      if (w_acc) begin
        r_addr    <= w_addr;
        r_din     <= w_wdata;
        r_rr_last <= w_id;
      end

      case (r_state)
        ST_IDLE: begin
          r_lock_cnt <= 4'd0;
          if (w_acc && w_lock) r_state <= w_id ? ST_OWN1 : ST_OWN0;
        end
        ST_OWN0, ST_OWN1: begin
          if (w_own_req) begin
            r_lock_cnt <= 4'd0;
            if (!w_lock) r_state <= ST_IDLE;
          end else if (r_lock_cnt == LOCK_LAST) begin
            r_lock_cnt <= 4'd0;
            r_state    <= ST_IDLE;
          end else begin
            r_lock_cnt <= r_lock_cnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  logic [7:0] mem [256];
  logic [3:0] conf_exp;

  ram_arbiter_if #(.M(8), .N(8)) bus ();

  ram_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h10]   <= 8'hA5;
      bus.ram_dout <= 8'h00;
    end else begin
      if (bus.ram_cs && bus.ram_wr) mem[bus.ram_addr] <= bus.ram_din;
      if (bus.ram_cs && bus.ram_rd) bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.lock0 = 0; bus.lock1 = 0; bus.addr0 = 0; bus.addr1 = 0;
    bus.wdata0 = 0; bus.wdata1 = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
`ifdef RAM_ARB_FIXED_PRIO_EN
    conf_exp = 4'b1111;
`else
    conf_exp = 4'b0101;
`endif
    do_reset();
    #1;
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_rvalid0", bus.rvalid0, 0);
    check("rst_rvalid1", bus.rvalid1, 0);
    check("rst_cs", bus.ram_cs, 0);
    check("rst_rd", bus.ram_rd, 0);
    check("rst_wr", bus.ram_wr, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_din", bus.ram_din, 0);

    // single read
    @(negedge clk); bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10; #1;
    check("rd_gnt0", bus.gnt0, 1);
    check("rd_gnt1", bus.gnt1, 0);
    @(negedge clk); bus.req0 = 0; #1;
    check("rd_cs", bus.ram_cs, 1);
    check("rd_rd", bus.ram_rd, 1);
    check("rd_wr", bus.ram_wr, 0);
    check("rd_addr", bus.ram_addr, 8'h10);
    check("rd_rvalid_early", bus.rvalid0, 0);
    @(negedge clk); #1;
    check("rd_rvalid0", bus.rvalid0, 1);
    check("rd_rdata", bus.rdata, 8'hA5);
    check("rd_rvalid1", bus.rvalid1, 0);
    check("rd_cs_idle", bus.ram_cs, 0);
    @(negedge clk); #1;
    check("rd_rvalid0_once", bus.rvalid0, 0);

    // write then read back from requester 1
    @(negedge clk); bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'hFF; bus.wdata1 = 8'h3C; #1;
    check("wr_gnt1", bus.gnt1, 1);
    @(negedge clk); bus.we1 = 0; #1;
    check("rb_gnt1", bus.gnt1, 1);
    check("wr_wr", bus.ram_wr, 1);
    check("wr_rd", bus.ram_rd, 0);
    check("wr_din", bus.ram_din, 8'h3C);
    check("wr_addr", bus.ram_addr, 8'hFF);
    @(negedge clk); bus.req1 = 0; #1;
    check("rb_rd", bus.ram_rd, 1);
    check("rb_wr", bus.ram_wr, 0);
    check("wr_no_rvalid", bus.rvalid1, 0);
    @(negedge clk); #1;
    check("rb_rvalid1", bus.rvalid1, 1);
    check("rb_rdata", bus.rdata, 8'h3C);
    check("rb_rvalid0", bus.rvalid0, 0);

    // conflict: both held for four cycles
    do_reset();
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 8'h10; bus.addr1 = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      if (i >= 4) begin bus.req0 = 0; bus.req1 = 0; end
      #1;
      if (i < 4) begin
        check("cf_gnt0", bus.gnt0, conf_exp[i]);
        check("cf_gnt1", bus.gnt1, !conf_exp[i]);
      end
      if (i >= 2) begin
        check("cf_rvalid0", bus.rvalid0, conf_exp[i-2]);
        check("cf_rvalid1", bus.rvalid1, !conf_exp[i-2]);
        check("cf_rdata", bus.rdata, conf_exp[i-2] ? 8'hA5 : 8'h3C);
      end
      @(negedge clk);
    end

    // lock held by requester 0 until an unlocked access
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.lock0 = 1; bus.addr0 = 8'h10; bus.req1 = 1; #1;
    check("lk_gnt0", bus.gnt0, 1);
    check("lk_gnt1", bus.gnt1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus.req0 = 0; bus.lock0 = 0; #1;
      check("lk_hold_gnt1", bus.gnt1, 0);
    end
    @(negedge clk); bus.req0 = 1; bus.we0 = 1; bus.wdata0 = 8'h77; bus.addr0 = 8'h20; #1;
    check("lk_unlock_gnt0", bus.gnt0, 1);
    check("lk_unlock_gnt1", bus.gnt1, 0);
    @(negedge clk); bus.req0 = 0; #1;
    check("lk_release_gnt1", bus.gnt1, 1);

    // lock timeout
    do_reset();
    bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 8'h10; bus.req1 = 1; #1;
    check("to_gnt0", bus.gnt0, 1);
    @(negedge clk); bus.req0 = 0; bus.lock0 = 0;
    for (int k = 1; k <= 15; k++) begin
      #1;
      check("to_hold_gnt1", bus.gnt1, 0);
      @(negedge clk);
    end
    #1;
    check("to_release_gnt1", bus.gnt1, 1);

    // reset in the middle of a locked read
    do_reset();
    bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 8'h10; #1;
    check("mr_gnt0", bus.gnt0, 1);
    @(negedge clk); bus.req0 = 0; bus.lock0 = 0; rst = 1; #1;
    check("mr_cs_before", bus.ram_cs, 1);
    @(negedge clk); rst = 0; bus.req1 = 1; #1;
    check("mr_rvalid0", bus.rvalid0, 0);
    check("mr_cs", bus.ram_cs, 0);
    check("mr_idle_gnt1", bus.gnt1, 1);
    @(negedge clk); idle_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
